// File: rtl/core_pkg.sv
// Shared types for the integer register-file write path.
package core_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // Source of the write that is registered onto the wb_* port this cycle.
  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LOAD_Q,
    WB_LOAD_BYP
  } wb_src_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Synchronous FIFO holding load responses that are waiting for the write slot.
module wb_load_fifo
  import core_pkg::*;
#(
  parameter type         T     = wb_req_t,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-port master: merges ALU results and queued load responses
// into one registered write stream and tracks pending destinations for hazard stalls.
module regfile_writeback #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rd_busy,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            idle
);

  import core_pkg::*;

  localparam int unsigned CW = $clog2(LQ_DEPTH) + 1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } lq_req_t;

  lq_req_t         lq_din;
  lq_req_t         lq_head;
  logic [CW-1:0]   lq_count;
  logic            lq_full;
  logic            lq_empty;
  logic            lq_push;
  logic            lq_pop;

  logic            alu_win;
  logic            ld_take;
  wb_src_t         src;

  logic            wb_en_nxt;
  logic [4:0]      wb_rd_nxt;
  logic [XLEN-1:0] wb_data_nxt;

  logic [31:0]     pending;
  logic [31:0]     pending_nxt;

  assign ld_ready = !lq_full;
  assign alu_win  = alu_valid && (alu_rd != '0);
  assign ld_take  = ld_valid && ld_ready && (ld_rd != '0);
  assign lq_din   = '{rd: ld_rd, data: ld_data};

  wb_load_fifo #(
    .T     (lq_req_t),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk   (clk),
    .rst   (rst),
    .push  (lq_push),
    .din   (lq_din),
    .pop   (lq_pop),
    .dout  (lq_head),
    .count (lq_count),
    .full  (lq_full),
    .empty (lq_empty)
  );

  // An incoming load bypasses the queue only when it is empty, so write order
  // among loads is always their acceptance order.
  always_comb begin
    src = WB_NONE;
    if (alu_win)        src = WB_ALU;
    else if (!lq_empty) src = WB_LOAD_Q;
    else if (ld_take)   src = WB_LOAD_BYP;
  end

  assign lq_pop  = (src == WB_LOAD_Q);
  assign lq_push = ld_take && (src != WB_LOAD_BYP);

  always_comb begin
    wb_en_nxt   = 1'b0;
    wb_rd_nxt   = wb_rd;
    wb_data_nxt = wb_data;
    unique case (src)
      WB_ALU: begin
        wb_en_nxt   = 1'b1;
        wb_rd_nxt   = alu_rd;
        wb_data_nxt = alu_data;
      end
      WB_LOAD_Q: begin
        wb_en_nxt   = 1'b1;
        wb_rd_nxt   = lq_head.rd;
        wb_data_nxt = lq_head.data;
      end
      WB_LOAD_BYP: begin
        wb_en_nxt   = 1'b1;
        wb_rd_nxt   = ld_rd;
        wb_data_nxt = ld_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      wb_en   <= wb_en_nxt;
      wb_rd   <= wb_rd_nxt;
      wb_data <= wb_data_nxt;
    end
  end

  // A new reservation in the same cycle as the retiring write keeps the bit set.
  always_comb begin
    pending_nxt = pending;
    if (wb_en)                          pending_nxt[wb_rd]  = 1'b0;
    if (iss_valid && (iss_rd != '0))    pending_nxt[iss_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= pending_nxt;
  end

  assign rs1_busy = pending[rs1];
  assign rs2_busy = pending[rs2];
  assign rd_busy  = iss_valid & pending[iss_rd];
  assign idle     = (pending == '0) && (lq_count == '0) && !wb_en;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed vector table, hand sequences and a random run.
module tb_regfile_writeback;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned LQ_DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            iss_valid;
  logic [4:0]      iss_rd, rs1, rs2;
  logic            rs1_busy, rs2_busy, rd_busy;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid, ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            idle;

  regfile_writeback #(.XLEN(XLEN), .LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .idle(idle)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic iv, input logic [4:0] ir, input logic [4:0] r1, input logic [4:0] r2,
                        input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    iss_valid = iv; iss_rd = ir; rs1 = r1; rs2 = r2;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_valid = lv; ld_rd = lr; ld_data = ld;
  endtask

  typedef struct {
    logic        iv;  logic [4:0] ir;  logic [4:0] r1;  logic [4:0] r2;
    logic        av;  logic [4:0] ar;  logic [31:0] ad;
    logic        lv;  logic [4:0] lr;  logic [31:0] ld;
    logic        e_r1, e_r2, e_rdb, e_ldr;
    logic        e_en; logic [4:0] e_rd; logic [31:0] e_data; logic e_idle;
  } vec_t;

  function automatic vec_t mk(int iv, int ir, int r1, int r2, int av, int ar, logic [31:0] ad,
                              int lv, int lr, logic [31:0] ld, int er1, int er2, int erdb, int eldr,
                              int een, int erd, logic [31:0] edata, int eidle);
    vec_t v;
    v.iv = 1'(iv); v.ir = 5'(ir); v.r1 = 5'(r1); v.r2 = 5'(r2);
    v.av = 1'(av); v.ar = 5'(ar); v.ad = ad;
    v.lv = 1'(lv); v.lr = 5'(lr); v.ld = ld;
    v.e_r1 = 1'(er1); v.e_r2 = 1'(er2); v.e_rdb = 1'(erdb); v.e_ldr = 1'(eldr);
    v.e_en = 1'(een); v.e_rd = 5'(erd); v.e_data = edata; v.e_idle = 1'(eidle);
    return v;
  endfunction

  // One cycle of the hand sequences: ALU/load inputs, expected ld_ready before the edge,
  // expected write after it.
  task automatic hs(input string nm, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                    input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                    input logic e_ldr, input logic e_en, input logic [4:0] e_rd, input logic [31:0] e_d);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, av, ar, ad, lv, lr, ld);
    #3;
    chk({nm, ".ld_ready"}, ld_ready, e_ldr);
    tick();
    chk({nm, ".wb_en"}, wb_en, e_en);
    if (e_en) begin
      chk({nm, ".wb_rd"}, wb_rd, e_rd);
      chk({nm, ".wb_data"}, wb_data, e_d);
    end
  endtask

  typedef struct { logic [4:0] rd; logic [31:0] d; } ld_ent_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t    vt [15];
    ld_ent_t mq [$];
    ld_ent_t e;
    logic [31:0] mpend;
    logic        m_en;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        x_ldr, alu_w;

    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    chk("reset.wb_en", wb_en, 1'b0);
    chk("reset.wb_rd", wb_rd, 5'd0);
    chk("reset.wb_data", wb_data, 32'd0);
    chk("reset.ld_ready", ld_ready, 1'b1);
    chk("reset.idle", idle, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    tick();

    //        iv ir r1 r2  av ar ad            lv lr ld        r1b r2b rdb ldr  en rd data         idle
    vt[0]  = mk(0, 0, 5, 0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,    0, 0, 0, 1,  1, 5, 32'hDEADBEEF, 0);
    vt[1]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 1,  0, 0, 32'h0,        1);
    vt[2]  = mk(0, 0, 0, 0, 1, 0, 32'h55,       1, 0, 32'h66,   0, 0, 0, 1,  0, 0, 32'h0,        1);
    vt[3]  = mk(1, 7, 7, 0, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 1,  0, 0, 32'h0,        0);
    vt[4]  = mk(0, 0, 7, 0, 0, 0, 32'h0,        0, 0, 32'h0,    1, 0, 0, 1,  0, 0, 32'h0,        0);
    vt[5]  = mk(0, 0, 7, 0, 0, 0, 32'h0,        1, 7, 32'h1234, 1, 0, 0, 1,  1, 7, 32'h1234,     0);
    vt[6]  = mk(0, 0, 7, 0, 0, 0, 32'h0,        0, 0, 32'h0,    1, 0, 0, 1,  0, 0, 32'h0,        1);
    vt[7]  = mk(0, 0, 7, 0, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 1,  0, 0, 32'h0,        1);
    vt[8]  = mk(1, 3, 0, 3, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 1,  0, 0, 32'h0,        0);
    vt[9]  = mk(0, 0, 0, 3, 1, 3, 32'hAA,       0, 0, 32'h0,    0, 1, 0, 1,  1, 3, 32'hAA,       0);
    vt[10] = mk(1, 3, 0, 3, 0, 0, 32'h0,        0, 0, 32'h0,    0, 1, 1, 1,  0, 0, 32'h0,        0);
    vt[11] = mk(0, 0, 0, 3, 0, 0, 32'h0,        0, 0, 32'h0,    0, 1, 0, 1,  0, 0, 32'h0,        0);
    vt[12] = mk(0, 0, 0, 3, 1, 3, 32'hBB,       0, 0, 32'h0,    0, 1, 0, 1,  1, 3, 32'hBB,       0);
    vt[13] = mk(0, 0, 0, 3, 0, 0, 32'h0,        0, 0, 32'h0,    0, 1, 0, 1,  0, 0, 32'h0,        1);
    vt[14] = mk(0, 0, 0, 3, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 1,  0, 0, 32'h0,        1);

    for (int i = 0; i < 15; i++) begin
      set_in(vt[i].iv, vt[i].ir, vt[i].r1, vt[i].r2, vt[i].av, vt[i].ar, vt[i].ad,
             vt[i].lv, vt[i].lr, vt[i].ld);
      #3;
      chk($sformatf("vec%0d.rs1_busy", i), rs1_busy, vt[i].e_r1);
      chk($sformatf("vec%0d.rs2_busy", i), rs2_busy, vt[i].e_r2);
      chk($sformatf("vec%0d.rd_busy", i), rd_busy, vt[i].e_rdb);
      chk($sformatf("vec%0d.ld_ready", i), ld_ready, vt[i].e_ldr);
      tick();
      chk($sformatf("vec%0d.wb_en", i), wb_en, vt[i].e_en);
      if (vt[i].e_en) begin
        chk($sformatf("vec%0d.wb_rd", i), wb_rd, vt[i].e_rd);
        chk($sformatf("vec%0d.wb_data", i), wb_data, vt[i].e_data);
      end
      chk($sformatf("vec%0d.idle", i), idle, vt[i].e_idle);
    end

    // Queue fills behind a stream of ALU writes, then drains in order.
    hs("fill.a", 1'b1, 5'd1, 32'h11, 1'b1, 5'd8,  32'h80, 1'b1, 1'b1, 5'd1, 32'h11);
    hs("fill.b", 1'b1, 5'd2, 32'h22, 1'b1, 5'd9,  32'h90, 1'b1, 1'b1, 5'd2, 32'h22);
    hs("fill.c", 1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 32'hA0, 1'b0, 1'b1, 5'd3, 32'h33);
    hs("fill.d", 1'b1, 5'd4, 32'h44, 1'b1, 5'd10, 32'hA0, 1'b0, 1'b1, 5'd4, 32'h44);
    hs("fill.e", 1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 5'd8, 32'h80);
    hs("fill.f", 1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 5'd9, 32'h90);
    hs("fill.g", 1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd0, 32'h0);
    chk("fill.idle", idle, 1'b1);

    // Mid-operation reset with two queued loads and a pending register.
    set_in(1'b1, 5'd12, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    hs("rst.a", 1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h200, 1'b1, 1'b1, 5'd1, 32'h1);
    hs("rst.b", 1'b1, 5'd2, 32'h2, 1'b1, 5'd21, 32'h210, 1'b1, 1'b1, 5'd2, 32'h2);
    set_in(1'b0, 5'd0, 5'd12, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    rst = 1'b0;
    #1;
    chk("rst.wb_en", wb_en, 1'b0);
    chk("rst.ld_ready", ld_ready, 1'b1);
    chk("rst.idle", idle, 1'b1);
    chk("rst.rs1_busy", rs1_busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rst.post%0d.wb_en", i), wb_en, 1'b0);
      chk($sformatf("rst.post%0d.idle", i), idle, 1'b1);
    end

    // Random traffic against a queue/array reference model.
    mpend = '0;
    m_en = 1'b0;
    m_rd = '0;
    m_data = '0;
    for (int c = 0; c < 400; c++) begin
      iss_valid = ($urandom_range(0, 9) < 4);
      iss_rd    = 5'($urandom_range(0, 31));
      rs1       = 5'($urandom_range(0, 31));
      rs2       = 5'($urandom_range(0, 31));
      alu_valid = ($urandom_range(0, 1) == 1);
      alu_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 1) == 1);
      ld_rd     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ld_data   = $urandom;
      #3;
      x_ldr = (mq.size() != LQ_DEPTH);
      chk($sformatf("rnd%0d.ld_ready", c), ld_ready, x_ldr);
      chk($sformatf("rnd%0d.rs1_busy", c), rs1_busy, (rs1 != 0) && mpend[rs1]);
      chk($sformatf("rnd%0d.rs2_busy", c), rs2_busy, (rs2 != 0) && mpend[rs2]);
      chk($sformatf("rnd%0d.rd_busy", c), rd_busy, iss_valid && (iss_rd != 0) && mpend[iss_rd]);

      if (ld_valid && x_ldr && (ld_rd != 0)) begin
        e.rd = ld_rd;
        e.d  = ld_data;
        mq.push_back(e);
      end
      if (m_en) mpend[m_rd] = 1'b0;
      if (iss_valid && (iss_rd != 0)) mpend[iss_rd] = 1'b1;
      alu_w = alu_valid && (alu_rd != 0);
      if (alu_w) begin
        m_en = 1'b1; m_rd = alu_rd; m_data = alu_data;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_en = 1'b1; m_rd = e.rd; m_data = e.d;
      end else begin
        m_en = 1'b0;
      end

      tick();
      chk($sformatf("rnd%0d.wb_en", c), wb_en, m_en);
      if (m_en) begin
        chk($sformatf("rnd%0d.wb_rd", c), wb_rd, m_rd);
        chk($sformatf("rnd%0d.wb_data", c), wb_data, m_data);
      end
      chk($sformatf("rnd%0d.idle", c), idle, (mpend == 0) && (mq.size() == 0) && !m_en);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
